dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 32-word data memory. It sits between the memory and two requesters: port 0 is the CPU load/store stage, and port 1 is the loader/debug path. It serializes their accesses with round-robin fairness and drives the memory's read/write strobes for exactly one cycle per transaction. It also returns read data to each port through a req/ack handshake.

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and strobe sequencer for the data memory
// Serializes port 0 (CPU) and port 1 (loader/debug) accesses: IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [31:0]       addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err,
  output logic              busy,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       Adress,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic                oor_q, oor_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d, busy_q, busy_d;
  logic                mem_read_q, mem_read_d, mem_write_q, mem_write_d;

  logic                win;
  logic                win_we;
  logic [31:0]         win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_oor;
  logic [DATA_W-1:0]   rd_capture;

  // Port 1 wins when it is the only requester or when port 0 was served last.
  assign win       = req1 & (~req0 | ~last_grant_q);
  assign win_we    = win ? we1 : we0;
  assign win_addr  = win ? addr1 : addr0;
  assign win_wdata = win ? wdata1 : wdata0;
  assign win_oor   = (win_addr >= DEPTH_W);
  assign rd_capture = oor_q ? '0 : ReadData;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req0 | req1) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered so strobes never glitch.
  always_comb begin
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    oor_d        = oor_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err_d        = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (state_d == S_ACCESS) begin
          gnt_d        = win;
          last_grant_d = win;
          we_d         = win_we;
          oor_d        = win_oor;
          addr_d       = win_addr;
          wdata_d      = win_wdata;
          mem_write_d  = win_we & ~win_oor;
          mem_read_d   = ~win_we & ~win_oor;
        end
      end
      S_ACCESS: begin
        ack0_d = ~gnt_q;
        ack1_d = gnt_q;
        err_d  = oor_q;
        if (!we_q) begin
          if (gnt_q) rdata1_d = rd_capture;
          else       rdata0_d = rd_capture;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      oor_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      oor_q        <= oor_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign MemRead   = mem_read_q;
  assign MemWrite  = mem_write_q;
  assign Adress    = addr_q;
  assign WriteData = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err, busy, MemRead, MemWrite;
  logic [31:0] rdata0, rdata1, Adress, WriteData, ReadData;
  logic [31:0] mem [32];

  int checks = 0;
  int passes = 0;
  int viol   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .err(err), .busy(busy), .MemRead(MemRead), .MemWrite(MemWrite),
    .Adress(Adress), .WriteData(WriteData), .ReadData(ReadData)
  );

  // Memory model: combinational read, write on the rising edge.
  assign ReadData = (Adress < 32) ? mem[Adress[4:0]] : 32'h0;
  always @(posedge clk) if (MemWrite && Adress < 32) mem[Adress[4:0]] <= WriteData;

  always @(negedge clk) if ((MemRead && MemWrite) || (ack0 && ack1)) viol++;

  typedef struct {
    string       name;
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [5:0]  f;   // ack0 ack1 err busy MemRead MemWrite
    logic        ca;  // compare Adress/WriteData
    logic [31:0] adr, wd, rd0, rd1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic rst,
                              logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic [5:0] f, logic ca, logic [31:0] adr, logic [31:0] wd,
                              logic [31:0] rd0, logic [31:0] rd1);
    vec_t v;
    v.name = n; v.rst = rst;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.f = f; v.ca = ca; v.adr = adr; v.wd = wd; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] A = 32'hA1A1A1A1;
  localparam logic [31:0] B = 32'hB2B2B2B2;
  localparam logic [31:0] C = 32'hC3C3C3C3;

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    reset = 1'b1; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

    // write / read-back / out-of-range / boundary
    vecs.push_back(mk("rst",       1, 0,0,0,0,        0,0,0,0,                  6'b000000,1, 0,0,  0,0));
    vecs.push_back(mk("wr0_acc",   0, 1,1,5,D,        0,0,0,0,                  6'b000101,1, 5,D,  0,0));
    vecs.push_back(mk("wr0_resp",  0, 1,1,5,D,        0,0,0,0,                  6'b100100,0, 0,0,  0,0));
    vecs.push_back(mk("wr0_idle",  0, 0,1,5,D,        0,0,0,0,                  6'b000000,0, 0,0,  0,0));
    vecs.push_back(mk("rd1_acc",   0, 0,0,0,0,        1,0,5,32'h11111111,       6'b000110,1, 5,32'h11111111, 0,0));
    vecs.push_back(mk("rd1_resp",  0, 0,0,0,0,        1,0,5,32'h11111111,       6'b010100,0, 0,0,  0,D));
    vecs.push_back(mk("rd1_idle",  0, 0,0,0,0,        0,0,5,0,                  6'b000000,0, 0,0,  0,D));
    vecs.push_back(mk("rd0_acc",   0, 1,0,5,0,        0,0,0,0,                  6'b000110,1, 5,0,  0,D));
    vecs.push_back(mk("rd0_resp",  0, 1,0,5,0,        0,0,0,0,                  6'b100100,0, 0,0,  D,D));
    vecs.push_back(mk("rd0_idle",  0, 0,0,5,0,        0,0,0,0,                  6'b000000,0, 0,0,  D,D));
    vecs.push_back(mk("oor_acc",   0, 1,0,40,0,       0,0,0,0,                  6'b000100,1, 40,0, D,D));
    vecs.push_back(mk("oor_resp",  0, 1,0,40,0,       0,0,0,0,                  6'b101100,0, 0,0,  0,D));
    vecs.push_back(mk("oor_idle",  0, 0,0,40,0,       0,0,0,0,                  6'b000000,0, 0,0,  0,D));
    vecs.push_back(mk("w31_acc",   0, 0,0,0,0,        1,1,31,C,                 6'b000101,1, 31,C, 0,D));
    vecs.push_back(mk("w31_resp",  0, 0,0,0,0,        1,1,31,C,                 6'b010100,0, 0,0,  0,D));
    vecs.push_back(mk("w31_idle",  0, 0,0,0,0,        0,1,31,C,                 6'b000000,0, 0,0,  0,D));
    vecs.push_back(mk("w32_acc",   0, 1,1,32,32'h5A5A5A5A, 0,0,0,0,             6'b000100,1, 32,32'h5A5A5A5A, 0,D));
    vecs.push_back(mk("w32_resp",  0, 1,1,32,32'h5A5A5A5A, 0,0,0,0,             6'b101100,0, 0,0,  0,D));
    vecs.push_back(mk("w32_idle",  0, 0,0,0,0,        0,0,0,0,                  6'b000000,0, 0,0,  0,D));
    // tie after reset: grants 0,1,0 with 3-cycle ack spacing
    vecs.push_back(mk("rst2",      1, 0,0,0,0,        0,0,0,0,                  6'b000000,1, 0,0,  0,0));
    vecs.push_back(mk("tie_acc0",  0, 1,1,1,A,        1,1,2,B,                  6'b000101,1, 1,A,  0,0));
    vecs.push_back(mk("tie_ack0",  0, 1,1,1,A,        1,1,2,B,                  6'b100100,0, 0,0,  0,0));
    vecs.push_back(mk("tie_idle0", 0, 1,1,1,A,        1,1,2,B,                  6'b000000,0, 0,0,  0,0));
    vecs.push_back(mk("tie_acc1",  0, 1,1,1,A,        1,1,2,B,                  6'b000101,1, 2,B,  0,0));
    vecs.push_back(mk("tie_ack1",  0, 1,1,1,A,        1,1,2,B,                  6'b010100,0, 0,0,  0,0));
    vecs.push_back(mk("tie_idle1", 0, 1,1,1,A,        1,1,2,B,                  6'b000000,0, 0,0,  0,0));
    vecs.push_back(mk("tie_acc0b", 0, 1,1,1,A,        1,1,2,B,                  6'b000101,1, 1,A,  0,0));
    vecs.push_back(mk("tie_ack0b", 0, 1,1,1,A,        1,1,2,B,                  6'b100100,0, 0,0,  0,0));
    vecs.push_back(mk("tie_end",   0, 0,0,0,0,        0,0,0,0,                  6'b000000,0, 0,0,  0,0));
    // reset in ACCESS of a port 1 write
    vecs.push_back(mk("w7_acc",    0, 0,0,0,0,        1,1,7,32'h77777777,       6'b000101,1, 7,32'h77777777, 0,0));
    vecs.push_back(mk("rst_mid",   1, 0,0,0,0,        1,1,7,32'h77777777,       6'b000000,1, 0,0,  0,0));
    vecs.push_back(mk("post_rst",  0, 0,0,0,0,        0,0,0,0,                  6'b000000,1, 0,0,  0,0));
    vecs.push_back(mk("tie2_acc",  0, 1,0,1,0,        1,0,2,0,                  6'b000110,1, 1,0,  0,0));
    vecs.push_back(mk("tie2_ack0", 0, 1,0,1,0,        1,0,2,0,                  6'b100100,0, 0,0,  A,0));
    vecs.push_back(mk("tie2_idle", 0, 0,0,0,0,        0,0,0,0,                  6'b000000,0, 0,0,  A,0));
    // req0 withdrawn during ACCESS of a read
    vecs.push_back(mk("drop_acc",  0, 1,0,2,0,        0,0,0,0,                  6'b000110,1, 2,0,  A,0));
    vecs.push_back(mk("drop_resp", 0, 0,0,2,0,        0,0,0,0,                  6'b100100,0, 0,0,  B,0));
    vecs.push_back(mk("drop_idle", 0, 0,0,2,0,        0,0,0,0,                  6'b000000,0, 0,0,  B,0));

    @(negedge clk);
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      @(posedge clk);
      @(negedge clk);
      chk({vecs[i].name, "_ctl"},
          {58'h0, ack0, ack1, err, busy, MemRead, MemWrite, rdata0, rdata1},
          {58'h0, vecs[i].f, vecs[i].rd0, vecs[i].rd1});
      if (vecs[i].ca)
        chk({vecs[i].name, "_bus"}, {64'h0, Adress, WriteData}, {64'h0, vecs[i].adr, vecs[i].wd});
    end

    // bounded wait: ack latency from an IDLE request sample
    reset = 0; req1 = 1; we1 = 1; addr1 = 3; wdata1 = 32'h33333333;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (ack1) break;
    end
    chk("ack1_latency", 128'(n), 128'd2);
    req1 = 0;
    repeat (2) @(negedge clk);
    chk("busy_after_lat", {127'h0, busy}, 128'd0);

    chk("mem3",  {96'h0, mem[3]},  {96'h0, 32'h33333333});
    chk("mem31", {96'h0, mem[31]}, {96'h0, C});
    chk("mem0_untouched_by_addr32", {96'h0, mem[0]}, 128'd0);
    chk("mem5", {96'h0, mem[5]}, {96'h0, D});
    chk("exclusive_strobe_ack", 128'(viol), 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
